// File: rtl/bip_demux_router.sv
// Registered 1-to-2 demultiplexer: one valid/ready producer steered by in_sel
// into two independent FIFOs (A when in_sel=1, B otherwise), each with a debug pop counter.
module bip_demux_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  // Channel index 0 is output A, index 1 is output B.
  logic [1:0]                  push;
  logic [1:0]                  pop;
  logic [1:0]                  full;
  logic [1:0]                  vld;
  logic [1:0]                  out_rdy;
  logic [1:0][WIDTH-1:0]       head;
  logic [1:0][CNT_W-1:0]       cnt;

  // Readiness looks only at registered occupancy, never at the sink readies.
  assign in_ready = rst_n & ~(in_sel ? full[0] : full[1]);
  assign push     = {~in_sel, in_sel} & {2{in_valid & in_ready}};
  assign out_rdy  = {b_ready, a_ready};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [CNT_W-1:0] pop_cnt;

    assign vld[g]  = (occ != '0);
    assign full[g] = (occ == OCC_W'(DEPTH));
    assign pop[g]  = vld[g] & out_rdy[g];
    assign head[g] = mem[rd_ptr];
    assign cnt[g]  = pop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        occ     <= '0;
        pop_cnt <= '0;
      end else begin
        if (push[g]) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (pop[g]) begin
          rd_ptr  <= rd_ptr + PTR_W'(1);
          pop_cnt <= pop_cnt + CNT_W'(1);
        end
        case ({push[g], pop[g]})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end
  end

  assign a_data  = head[0];
  assign b_data  = head[1];
  assign a_valid = vld[0];
  assign b_valid = vld[1];
  assign a_count = cnt[0];
  assign b_count = cnt[1];

endmodule

// File: tb/tb_bip_demux_router.sv
// Self-checking bench for bip_demux_router: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_bip_demux_router;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  bip_demux_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: one queue per output plus wrapping delivered counts.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic [CNT_W-1:0] ca;
  logic [CNT_W-1:0] cb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    ca = '0;
    cb = '0;
  endtask

  // Check outputs against the model for the current inputs, advance the model
  // by the handshakes that will fire at the next edge, then step past that edge.
  task automatic cycle();
    logic exp_rdy;
    #1;
    exp_rdy = in_sel ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) chk("a_data", 32'(a_data), 32'(qa[0]));
    if (qb.size() != 0) chk("b_data", 32'(b_data), 32'(qb[0]));
    chk("a_count", 32'(a_count), 32'(ca));
    chk("b_count", 32'(b_count), 32'(cb));
    if (qa.size() != 0 && a_ready) begin void'(qa.pop_front()); ca++; end
    if (qb.size() != 0 && b_ready) begin void'(qb.pop_front()); cb++; end
    if (in_valid && exp_rdy) begin
      if (in_sel) qa.push_back(in_data);
      else        qb.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic             sel;
    logic             vld;
    logic [WIDTH-1:0] data;
    logic             ar;
    logic             br;
    logic             e_rdy;
    logic             e_av;
    logic [WIDTH-1:0] e_ad;
    logic             e_bv;
    logic [WIDTH-1:0] e_bd;
    logic [CNT_W-1:0] e_ac;
    logic [CNT_W-1:0] e_bc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Steering, then A backpressure/full with a B push alongside, then drain.
    vecs[0]  = '{1, 1, 16'h1234, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 0, 0};
    vecs[1]  = '{0, 1, 16'hABCD, 1, 1,  1, 1, 16'h1234, 0, 16'h0000, 0, 0};
    vecs[2]  = '{0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 1, 16'hABCD, 1, 0};
    vecs[3]  = '{0, 0, 16'h0000, 1, 1,  1, 0, 16'h0000, 0, 16'h0000, 1, 1};
    vecs[4]  = '{1, 1, 16'h0001, 0, 1,  1, 0, 16'h0000, 0, 16'h0000, 1, 1};
    vecs[5]  = '{1, 1, 16'h0002, 0, 1,  1, 1, 16'h0001, 0, 16'h0000, 1, 1};
    vecs[6]  = '{1, 1, 16'h0003, 0, 1,  0, 1, 16'h0001, 0, 16'h0000, 1, 1};
    vecs[7]  = '{0, 1, 16'h0004, 0, 0,  1, 1, 16'h0001, 0, 16'h0000, 1, 1};
    vecs[8]  = '{1, 0, 16'h0000, 1, 0,  0, 1, 16'h0001, 1, 16'h0004, 1, 1};
    vecs[9]  = '{1, 0, 16'h0000, 1, 0,  1, 1, 16'h0002, 1, 16'h0004, 2, 1};
    vecs[10] = '{1, 0, 16'h0000, 0, 1,  1, 0, 16'h0000, 1, 16'h0004, 3, 1};
    vecs[11] = '{1, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 0, 16'h0000, 3, 2};

    // Reset held with a pending producer word.
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h5555;
    a_ready = 1'b1; b_ready = 1'b1;
    model_reset();
    #8;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_a_valid", 32'(a_valid), 0);
    chk("rst_b_valid", 32'(b_valid), 0);
    chk("rst_a_data", 32'(a_data), 0);
    chk("rst_b_data", 32'(b_data), 0);
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_b_count", 32'(b_count), 0);
    in_valid = 1'b0;
    #4 rst_n = 1'b1;
    #1 chk("rel_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      in_sel = vecs[i].sel; in_valid = vecs[i].vld; in_data = vecs[i].data;
      a_ready = vecs[i].ar; b_ready = vecs[i].br;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("tbl%0d_a_valid", i), 32'(a_valid), 32'(vecs[i].e_av));
      chk($sformatf("tbl%0d_b_valid", i), 32'(b_valid), 32'(vecs[i].e_bv));
      if (vecs[i].e_av) chk($sformatf("tbl%0d_a_data", i), 32'(a_data), 32'(vecs[i].e_ad));
      if (vecs[i].e_bv) chk($sformatf("tbl%0d_b_data", i), 32'(b_data), 32'(vecs[i].e_bd));
      chk($sformatf("tbl%0d_a_count", i), 32'(a_count), 32'(vecs[i].e_ac));
      chk($sformatf("tbl%0d_b_count", i), 32'(b_count), 32'(vecs[i].e_bc));
      cycle();
    end

    // Simultaneous push+pop on A at occupancy 1 for 10 cycles.
    in_valid = 1'b1; in_sel = 1'b1; in_data = 16'h00EE; a_ready = 1'b0; b_ready = 1'b1;
    cycle();
    a_ready = 1'b1; in_data = 16'h00FF;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("pp_occ1_a_valid", 32'(a_valid), 1);
      chk("pp_occ1_in_ready", 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    cycle();
    chk("pp_a_count", 32'(a_count), 32'(8'd3 + 8'd11));
    cycle();

    // B counter wrap: 256 more deliveries on B return it to its starting value.
    in_valid = 1'b1; in_sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_data = WIDTH'(i);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("wrap_b_count", 32'(b_count), 32'(8'd2));
    chk("wrap_a_count", 32'(a_count), 32'(8'd14));

    // Mid-operation asynchronous reset pulse with A full.
    a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b1;
    in_data = 16'hC001; cycle();
    in_data = 16'hC002; cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", 32'(a_valid), 0);
    chk("mid_rst_a_count", 32'(a_count), 0);
    chk("mid_rst_b_count", 32'(b_count), 0);
    chk("mid_rst_a_data", 32'(a_data), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    #1 rst_n = 1'b1;
    model_reset();
    a_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_sel   = 1'($urandom_range(0, 1));
      in_data  = WIDTH'($urandom);
      a_ready  = ($urandom_range(0, 9) < 6);
      b_ready  = ($urandom_range(0, 9) < 4);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
